// File: rtl/video_frame_tracker_if.sv
// Decoded HDMI pixel stream as seen by the frame tracker.
// Defines the RGB plus de/hsync/vsync signal bundle.
interface video_frame_tracker_if;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic [7:0] blue_in;
    logic [7:0] green_in;
    logic [7:0] red_in;

    modport master (
        output de, hsync, vsync,
        output blue_in, green_in, red_in
    );

    modport slave (
        input de, hsync, vsync,
        input blue_in, green_in, red_in
    );
endinterface

// File: rtl/video_frame_tracker.sv
// Re-times the pixel stream, annotates pixels with x/y, sof and eol, and locks on stable timing.
// Optional frame_count port is enabled by defining VIDEO_FRAME_COUNT_EN.
module video_frame_tracker #(
    parameter int X_W         = 12,
    parameter int Y_W         = 11,
    parameter int LOCK_FRAMES = 4,
    parameter int WD_W        = 23
) (
    input  logic                   pix_1x_clk,
    input  logic                   reset_in,
    video_frame_tracker_if.slave   vid,
    output logic [7:0]             blue_out,
    output logic [7:0]             green_out,
    output logic [7:0]             red_out,
    output logic                   de_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic [X_W-1:0]         x_pos,
    output logic [Y_W-1:0]         y_pos,
    output logic                   sof,
    output logic                   eol,
    output logic [X_W-1:0]         active_width,
    output logic [Y_W-1:0]         active_height,
    output logic                   locked,
    output logic                   timing_err
`ifdef VIDEO_FRAME_COUNT_EN
    ,
    output logic [15:0]            frame_count
`endif
);

    localparam int S_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [S_W-1:0] S_MAX = S_W'(LOCK_FRAMES);
    localparam logic [WD_W-1:0] WD_MAX = {WD_W{1'b1}};
    localparam logic [WD_W-1:0] WD_TRIP = WD_MAX - WD_W'(1);

    logic [X_W-1:0]  first_w;
    logic            first_done;
    logic            w_mismatch;
    logic            frame_seen;
    logic [S_W-1:0]  stable;
    logic [WD_W-1:0] wd;

    logic            vs_rise;
    logic            de_rise;
    logic            de_fall;
    logic [X_W-1:0]  line_w;
    logic [Y_W-1:0]  y_inc;
    logic [X_W-1:0]  cand_w;
    logic [Y_W-1:0]  cand_h;
    logic            cand_bad;
    logic            cand_same;
    logic [S_W-1:0]  stable_inc;
    logic            wd_trip;

    // de_out and vsync_out double as the one-cycle delayed copies
    assign vs_rise = vid.vsync & ~vsync_out;
    assign de_rise = vid.de & ~de_out;
    assign de_fall = ~vid.de & de_out;
    assign eol     = de_fall;
    assign sof     = de_out & (x_pos == '0) & (y_pos == '0) & frame_seen;
    assign wd_trip = ~vs_rise & (wd == WD_TRIP);

    // Candidate frame geometry, folding in a line that ends on the vsync edge
    always_comb begin
        line_w     = x_pos + X_W'(1);
        y_inc      = (&y_pos) ? y_pos : y_pos + Y_W'(1);
        cand_w     = (de_fall & ~first_done) ? line_w : first_w;
        cand_h     = de_fall ? y_inc : y_pos;
        cand_bad   = (cand_h == '0) | w_mismatch
                   | (de_fall & first_done & (line_w != first_w));
        cand_same  = (cand_w == active_width) & (cand_h == active_height);
        stable_inc = (stable == S_MAX) ? stable : stable + S_W'(1);
    end

    // One-cycle re-timing of the pixel stream
    always_ff @(posedge pix_1x_clk or negedge reset_in) begin
        if (!reset_in) begin
            blue_out  <= '0;
            green_out <= '0;
            red_out   <= '0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            blue_out  <= vid.blue_in;
            green_out <= vid.green_in;
            red_out   <= vid.red_in;
            de_out    <= vid.de;
            hsync_out <= vid.hsync;
            vsync_out <= vid.vsync;
        end
    end

    // Pixel/line counters and first-line width tracking
    always_ff @(posedge pix_1x_clk or negedge reset_in) begin
        if (!reset_in) begin
            x_pos      <= '0;
            y_pos      <= '0;
            first_w    <= '0;
            first_done <= 1'b0;
            w_mismatch <= 1'b0;
        end else begin
            if (de_rise) begin
                x_pos <= '0;
            end else if (vid.de && !(&x_pos)) begin
                x_pos <= x_pos + X_W'(1);
            end
            if (vs_rise) begin
                y_pos      <= '0;
                first_done <= 1'b0;
                w_mismatch <= 1'b0;
            end else if (de_fall) begin
                y_pos <= y_inc;
                if (!first_done) begin
                    first_w    <= line_w;
                    first_done <= 1'b1;
                end else if (line_w != first_w) begin
                    w_mismatch <= 1'b1;
                end
            end
        end
    end

    // Frame commit, lock tracking and watchdog
    always_ff @(posedge pix_1x_clk or negedge reset_in) begin
        if (!reset_in) begin
            frame_seen    <= 1'b0;
            stable        <= '0;
            locked        <= 1'b0;
            timing_err    <= 1'b0;
            active_width  <= '0;
            active_height <= '0;
            wd            <= '0;
`ifdef VIDEO_FRAME_COUNT_EN
            frame_count   <= '0;
`endif
        end else begin
            timing_err <= 1'b0;
            if (vs_rise) begin
                wd <= '0;
                if (!frame_seen) begin
                    frame_seen <= 1'b1;
                end else begin
`ifdef VIDEO_FRAME_COUNT_EN
                    frame_count <= frame_count + 16'd1;
`endif
                    if (cand_bad) begin
                        stable     <= '0;
                        locked     <= 1'b0;
                        timing_err <= locked;
                    end else if (cand_same) begin
                        stable <= stable_inc;
                        locked <= (stable_inc == S_MAX);
                    end else begin
                        active_width  <= cand_w;
                        active_height <= cand_h;
                        stable        <= S_W'(1);
                        locked        <= (LOCK_FRAMES == 1);
                        timing_err    <= locked;
                    end
                end
            end else if (wd_trip) begin
                wd         <= WD_MAX;
                locked     <= 1'b0;
                stable     <= '0;
                frame_seen <= 1'b0;
                timing_err <= locked;
            end else if (wd != WD_MAX) begin
                wd <= wd + WD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_video_frame_tracker.sv
// Directed bench for video_frame_tracker: 8x4/10x4 frames, mismatch, overlap, watchdog, reset.
// Builds with or without VIDEO_FRAME_COUNT_EN.
module tb_video_frame_tracker;
    localparam int X_W = 12;
    localparam int Y_W = 11;
    localparam int LF  = 4;
    localparam int WDW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_frame_tracker_if vif ();

    logic [7:0]     b_o, g_o, r_o;
    logic           de_o, hs_o, vs_o;
    logic [X_W-1:0] x_pos, aw;
    logic [Y_W-1:0] y_pos, ah;
    logic           sof, eol, locked, terr;
`ifdef VIDEO_FRAME_COUNT_EN
    logic [15:0]    fc;
`endif

    video_frame_tracker #(
        .X_W(X_W), .Y_W(Y_W), .LOCK_FRAMES(LF), .WD_W(WDW)
    ) dut (
        .pix_1x_clk(clk), .reset_in(rst_n), .vid(vif.slave),
        .blue_out(b_o), .green_out(g_o), .red_out(r_o),
        .de_out(de_o), .hsync_out(hs_o), .vsync_out(vs_o),
        .x_pos(x_pos), .y_pos(y_pos), .sof(sof), .eol(eol),
        .active_width(aw), .active_height(ah),
        .locked(locked), .timing_err(terr)
`ifdef VIDEO_FRAME_COUNT_EN
        , .frame_count(fc)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic       prev_de, prev_vs;
    logic [7:0] prev_b;
    int         prev_x, prev_lw;
    bit         armed;

    int pipe_bad, x_bad, y_bad, eol_bad, sof_bad;
    int sof_cnt, eol_cnt, te_cnt;
    int vs_cyc;
    logic lk_at_vs;
    logic [15:0] fc_at_vs;

    task automatic clear_prev();
        prev_de = 1'b0;
        prev_vs = 1'b0;
        prev_b  = 8'h0;
        prev_x  = 0;
        prev_lw = 1;
    endtask

    task automatic step(input logic d, input logic h, input logic v,
                        input int x, input int ln, input int lw);
        logic [7:0] b, g, r;
        logic exp_eol, exp_sof;
        b = d ? 8'($urandom) : 8'h00;
        g = d ? 8'($urandom) : 8'h00;
        r = d ? 8'($urandom) : 8'h00;
        vif.de = d; vif.hsync = h; vif.vsync = v;
        vif.blue_in = b; vif.green_in = g; vif.red_in = r;
        #1;
        exp_eol = prev_de && (prev_x == prev_lw - 1);
        if (eol !== exp_eol) eol_bad++;
        if (eol === 1'b1) eol_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (de_o !== d || hs_o !== h || vs_o !== v) pipe_bad++;
        if (b_o !== b || g_o !== g || r_o !== r) pipe_bad++;
        if (d && x_pos !== X_W'(x)) x_bad++;
        if (d && y_pos !== Y_W'(ln)) y_bad++;
        if (v && !prev_vs) begin
            armed = 1'b1;
            vs_cyc = cyc;
            lk_at_vs = locked;
`ifdef VIDEO_FRAME_COUNT_EN
            fc_at_vs = fc;
`else
            fc_at_vs = 16'h0;
`endif
        end
        exp_sof = d && (x == 0) && (ln == 0) && armed;
        if (sof !== exp_sof) sof_bad++;
        if (sof === 1'b1) sof_cnt++;
        if (terr === 1'b1) te_cnt++;
        prev_de = d; prev_vs = v; prev_b = b;
        prev_x = x; prev_lw = lw;
    endtask

    task automatic drive_frame(input int w, input int bad_ln,
                               input int bad_w, input bit no_tail);
        int lw;
        sof_cnt = 0; eol_cnt = 0; te_cnt = 0;
        step(1'b0, 1'b0, 1'b1, 0, 0, 1);
        step(1'b0, 1'b0, 1'b1, 0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1);
        for (int ln = 0; ln < 4; ln++) begin
            lw = (ln == bad_ln) ? bad_w : w;
            for (int x = 0; x < lw; x++) step(1'b1, 1'b0, 1'b0, x, ln, lw);
            if (!(no_tail && ln == 3)) begin
                for (int k = 0; k < 4; k++) step(1'b0, k < 2, 1'b0, 0, 0, 1);
            end
        end
    endtask

    task automatic test_reset();
        vif.de = 0; vif.hsync = 0; vif.vsync = 0;
        vif.blue_in = 0; vif.green_in = 0; vif.red_in = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({b_o, g_o, r_o, de_o, hs_o, vs_o} !== 27'h0) begin
            n_fail++;
            $display("FAIL reset_pipe: got %h expected 0", {b_o, g_o, r_o, de_o, hs_o, vs_o});
        end
        n_chk++;
        if ({x_pos, y_pos, sof, eol} !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_pos: got %h expected 0", {x_pos, y_pos, sof, eol});
        end
        n_chk++;
        if ({aw, ah, locked, terr} !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_timing: got %h expected 0", {aw, ah, locked, terr});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_prev();
        armed = 1'b0;
    endtask

    task automatic test_basic_lock();
        logic [4:0] lk;
        int sof_ok, eol_ok;
        sof_ok = 0; eol_ok = 0;
        for (int f = 0; f < 5; f++) begin
            drive_frame(8, -1, 0, 1'b0);
            lk[f] = lk_at_vs;
            if (sof_cnt == 1) sof_ok++;
            if (eol_cnt == 4) eol_ok++;
        end
        n_chk++;
        if (lk !== 5'b10000) begin
            n_fail++;
            $display("FAIL basic_lock_seq: got %b expected 10000", lk);
        end
        n_chk++;
        if (aw !== 12'd8 || ah !== 11'd4) begin
            n_fail++;
            $display("FAIL basic_geom: got %0dx%0d expected 8x4", aw, ah);
        end
        n_chk++;
        if (sof_ok != 5) begin
            n_fail++;
            $display("FAIL basic_sof_once: got %0d frames expected 5", sof_ok);
        end
        n_chk++;
        if (eol_ok != 5) begin
            n_fail++;
            $display("FAIL basic_eol_count: got %0d frames expected 5", eol_ok);
        end
    endtask

    task automatic test_overlap();
        drive_frame(8, -1, 0, 1'b1);
        drive_frame(8, -1, 0, 1'b0);
        n_chk++;
        if (ah !== 11'd4) begin
            n_fail++;
            $display("FAIL overlap_height: got %0d expected 4", ah);
        end
        n_chk++;
        if (locked !== 1'b1 || te_cnt != 0) begin
            n_fail++;
            $display("FAIL overlap_lock: got locked=%b te=%0d expected 1/0", locked, te_cnt);
        end
    endtask

    task automatic test_line_mismatch();
        drive_frame(8, 1, 7, 1'b0);
        drive_frame(8, -1, 0, 1'b0);
        n_chk++;
        if (lk_at_vs !== 1'b0 || te_cnt != 1) begin
            n_fail++;
            $display("FAIL mismatch_reject: got locked=%b te=%0d expected 0/1", lk_at_vs, te_cnt);
        end
        n_chk++;
        if (aw !== 12'd8 || ah !== 11'd4) begin
            n_fail++;
            $display("FAIL mismatch_keep: got %0dx%0d expected 8x4", aw, ah);
        end
        for (int f = 0; f < 3; f++) drive_frame(8, -1, 0, 1'b0);
        n_chk++;
        if (lk_at_vs !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch_early: got %b expected 0", lk_at_vs);
        end
        drive_frame(8, -1, 0, 1'b0);
        n_chk++;
        if (lk_at_vs !== 1'b1) begin
            n_fail++;
            $display("FAIL mismatch_relock: got %b expected 1", lk_at_vs);
        end
    endtask

    task automatic test_width_change();
        drive_frame(10, -1, 0, 1'b0);
        drive_frame(10, -1, 0, 1'b0);
        n_chk++;
        if (te_cnt != 1 || lk_at_vs !== 1'b0) begin
            n_fail++;
            $display("FAIL width_err: got te=%0d locked=%b expected 1/0", te_cnt, lk_at_vs);
        end
        n_chk++;
        if (aw !== 12'd10 || ah !== 11'd4) begin
            n_fail++;
            $display("FAIL width_geom: got %0dx%0d expected 10x4", aw, ah);
        end
        drive_frame(10, -1, 0, 1'b0);
        drive_frame(10, -1, 0, 1'b0);
        n_chk++;
        if (lk_at_vs !== 1'b0) begin
            n_fail++;
            $display("FAIL width_early: got %b expected 0", lk_at_vs);
        end
        drive_frame(10, -1, 0, 1'b0);
        n_chk++;
        if (lk_at_vs !== 1'b1) begin
            n_fail++;
            $display("FAIL width_relock: got %b expected 1", lk_at_vs);
        end
    endtask

    task automatic test_watchdog();
        int n;
        te_cnt = 0;
        n = 0;
        while (locked === 1'b1 && n < 200) begin
            step(1'b0, 1'b0, 1'b0, 0, 0, 1);
            n++;
        end
        n_chk++;
        if (cyc - vs_cyc != 63) begin
            n_fail++;
            $display("FAIL wd_delay: got %0d expected 63", cyc - vs_cyc);
        end
        armed = 1'b0;
        repeat (10) step(1'b0, 1'b0, 1'b0, 0, 0, 1);
        n_chk++;
        if (te_cnt != 1 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_err: got te=%0d locked=%b expected 1/0", te_cnt, locked);
        end
        for (int f = 0; f < 4; f++) drive_frame(8, -1, 0, 1'b0);
        n_chk++;
        if (lk_at_vs !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_arm_only: got %b expected 0", lk_at_vs);
        end
        drive_frame(8, -1, 0, 1'b0);
        n_chk++;
        if (lk_at_vs !== 1'b1 || aw !== 12'd8) begin
            n_fail++;
            $display("FAIL wd_relock: got locked=%b w=%0d expected 1/8", lk_at_vs, aw);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] fcs [5];
        logic        lks [5];
        drive_frame(8, -1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1);
        step(1'b1, 1'b0, 1'b0, 0, 0, 99);
        step(1'b1, 1'b0, 1'b0, 1, 0, 99);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({de_o, b_o, x_pos, aw, ah, locked, sof, eol} !== 45'h0) begin
            n_fail++;
            $display("FAIL midreset_zero: got %h expected 0",
                     {de_o, b_o, x_pos, aw, ah, locked, sof, eol});
        end
`ifdef VIDEO_FRAME_COUNT_EN
        n_chk++;
        if (fc !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_fc: got %0d expected 0", fc);
        end
`endif
        vif.de = 0; vif.vsync = 0; vif.hsync = 0;
        vif.blue_in = 0; vif.green_in = 0; vif.red_in = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_prev();
        armed = 1'b0;
        for (int f = 0; f < 5; f++) begin
            drive_frame(8, -1, 0, 1'b0);
            lks[f] = lk_at_vs;
            fcs[f] = fc_at_vs;
        end
        n_chk++;
        if (lks[3] !== 1'b0 || lks[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_lock: got %b%b expected 01", lks[3], lks[4]);
        end
`ifdef VIDEO_FRAME_COUNT_EN
        n_chk++;
        if (fcs[0] !== 16'd0 || fcs[1] !== 16'd1 || fcs[2] !== 16'd2 || fcs[4] !== 16'd4) begin
            n_fail++;
            $display("FAIL frame_count: got %0d,%0d,%0d,%0d expected 0,1,2,4",
                     fcs[0], fcs[1], fcs[2], fcs[4]);
        end
`endif
    endtask

    task automatic test_stream_checks();
        n_chk++;
        if (pipe_bad != 0) begin
            n_fail++;
            $display("FAIL pipe_latency: got %0d bad cycles expected 0", pipe_bad);
        end
        n_chk++;
        if (x_bad != 0 || y_bad != 0) begin
            n_fail++;
            $display("FAIL xy_pos: got %0d/%0d bad expected 0/0", x_bad, y_bad);
        end
        n_chk++;
        if (eol_bad != 0) begin
            n_fail++;
            $display("FAIL eol_align: got %0d bad expected 0", eol_bad);
        end
        n_chk++;
        if (sof_bad != 0) begin
            n_fail++;
            $display("FAIL sof_align: got %0d bad expected 0", sof_bad);
        end
    endtask

    initial begin
        pipe_bad = 0; x_bad = 0; y_bad = 0; eol_bad = 0; sof_bad = 0;
        sof_cnt = 0; eol_cnt = 0; te_cnt = 0; vs_cyc = 0;
        lk_at_vs = 1'b0; fc_at_vs = 16'h0; armed = 1'b0;
        clear_prev();
        test_reset();
        test_basic_lock();
        test_overlap();
        test_line_mismatch();
        test_width_change();
        test_watchdog();
        test_reset_mid();
        test_stream_checks();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/video_frame_tracker.md
Name: video_frame_tracker

Overview:
- Sits directly downstream of the HDMI receiver, in the pix_1x_clk domain.
- Consumes decoded RGB plus de/hsync/vsync, and re-emits them with a 1-cycle register stage.
- Annotates each pixel with x/y position, start-of-frame and end-of-line markers.
- Measures active width/height per frame and asserts `locked` once the timing has been stable for LOCK_FRAMES frames. Later processing stages (flip, scaler, overlay) key off these outputs.

Parameters:
- X_W, 12, width of x counter and active_width.
- Y_W, 11, width of y counter and active_height.
- LOCK_FRAMES, 4, consecutive identical frames required before `locked`.
- WD_W, 23, watchdog counter width; `locked` drops if no frame boundary occurs within 2^WD_W cycles.

Ports:
- pix_1x_clk, in, 1, pixel clock from the HDMI receiver.
- reset_in, in, 1, asynchronous, active-low reset.
- de, in, 1, data enable.
- hsync, in, 1, active-high horizontal sync.
- vsync, in, 1, active-high vertical sync.
- blue_in, in, 8, ch0 pixel.
- green_in, in, 8, ch1 pixel.
- red_in, in, 8, ch2 pixel.
- blue_out, out, 8, registered blue_in.
- green_out, out, 8, registered green_in.
- red_out, out, 8, registered red_in.
- de_out, out, 1, registered de.
- hsync_out, out, 1, registered hsync.
- vsync_out, out, 1, registered vsync.
- x_pos, out, X_W, column of the current output pixel.
- y_pos, out, Y_W, row of the current output pixel.
- sof, out, 1, high with the first active pixel of a frame.
- eol, out, 1, high with the last active pixel of a line.
- active_width, out, X_W, committed active pixels per line.
- active_height, out, Y_W, committed active lines per frame.
- locked, out, 1, timing stable.
- timing_err, out, 1, 1-cycle pulse when a locked stream changes timing.

Behaviour:
Reset
- Reset: asynchronous, active-low on reset_in.
- All outputs 0 while reset_in=0, including active_width/active_height.
- All internal state cleared, including frame_seen=0.

Pipeline
- Latency is exactly 1 cycle: RGB, de, hsync and vsync appear on the `_out` ports one cycle after input.
- x_pos, y_pos, sof and eol are aligned with de_out.
- x_pos and y_pos are don't-care when de_out=0.

Edge detection
- Edge detection uses de_d, vsync_d, registered one cycle.
- vs_rise = vsync & !vsync_d.
- de_rise = de & !de_d.
- de_fall = !de & de_d.

Counting
- x count: 0 on de_rise; +1 on each further de cycle; saturates at 2^X_W-1.
- eol = de_d & !de, i.e. the registered pixel is the last of its line.
- On de_fall:
  - line_w = x+1.
  - y_cnt increments, saturating.
  - If this is the first line of the frame, store first_w.
  - Otherwise, if line_w != first_w, set w_mismatch.
- y_pos = number of completed lines in the current frame.
- sof = de_out & x_pos==0 & y_pos==0 & frame_seen.

Frame boundary on vs_rise
- If frame_seen=0: set frame_seen, clear counters, do not commit.
- Otherwise, commit: cand_w = first_w, cand_h = y_cnt.
- If cand_h==0 or w_mismatch=1:
  - stable=0, locked=0.
  - active_width/height keep their previous values.
- Else, if cand_w/cand_h equal active_width/active_height: stable increments, saturating at LOCK_FRAMES.
- Else:
  - Load active_width/height from cand_w/cand_h.
  - stable=1.
- locked = (stable==LOCK_FRAMES), updated on the same edge.
- timing_err pulses if locked was 1 and the commit did not increment `stable`.
- Clear y_cnt, first-line flag and w_mismatch. Clear the watchdog.

Watchdog
- Watchdog increments every cycle and clears on vs_rise.
- On reaching 2^WD_W-1: locked=0, stable=0, frame_seen=0, timing_err pulses if it was locked; the watchdog then holds.

Simultaneous events
- de_fall together with vs_rise: the line counts toward the ending frame before the commit.
- de_rise together with vs_rise: the pixel is x=0, y=0 of the new frame.
- Reset mid-frame: after release, the first vs_rise only arms the block; the earliest possible lock is LOCK_FRAMES+1 vs_rise edges later.

Optional Feature:
- Macro: VIDEO_FRAME_COUNT_EN.
- When defined:
  - Adds output port frame_count, 16 bits, reset 0.
  - frame_count increments on every committed vs_rise and wraps 0xFFFF→0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset at 0, then drive 5 frames of 8x4 active, 4-cycle hblank, vsync pulse per frame (LOCK_FRAMES=4) -> de_out delayed 1 cycle; x_pos 0..7; eol on x=7; sof once per frame; locked rises at 5th vs_rise; active_width=8, active_height=4.
- Locked on 8x4, then one frame of 10x4 -> timing_err 1-cycle pulse; locked=0; active_width=10; relock after 3 further 10x4 frames.
- Frame where line 2 is 7 pixels wide -> commit rejected; locked=0; active_width/height unchanged at 8/4.
- Locked, then vsync held low with WD_W=6 -> locked falls 63 cycles after last vs_rise with timing_err pulse; next vs_rise arms only.
- de_fall and vs_rise in the same cycle -> active_height includes that line (4, not 3).
- reset_in pulsed low mid-line -> all outputs 0 asynchronously; lock requires 5 vs_rise edges after release; with VIDEO_FRAME_COUNT_EN, frame_count=0 then counts 1,2,... per committed frame.
